// File: rtl/sale_entry_ctrl_if.sv
// Lookup channel between the sale entry controller (master) and the item price table (slave).
interface sale_entry_ctrl_if #(
    parameter int DIGITS  = 4,
    parameter int PRICE_W = 10
);
    // Handshake: the master raises lookup_req together with lookup_code and holds both stable
    // until the slave answers with a one-cycle lookup_ack; lookup_hit and lookup_price are
    // meaningful only in the lookup_ack cycle, and lookup_req drops the cycle after it.
    logic                lookup_req;
    logic [2*DIGITS-1:0] lookup_code;
    logic                lookup_ack;
    logic                lookup_hit;
    logic [PRICE_W-1:0]  lookup_price;

    modport master (
        output lookup_req, lookup_code,
        input  lookup_ack, lookup_hit, lookup_price
    );

    modport slave (
        input  lookup_req, lookup_code,
        output lookup_ack, lookup_hit, lookup_price
    );
endinterface

// File: rtl/sale_entry_ctrl.sv
// Front-panel sale entry: debounced keys build a barcode, a request/acknowledge lookup
// fetches its price, and hits accumulate into a saturating sale total.
module sale_entry_ctrl #(
    parameter int DIGITS     = 4,
    parameter int DEB_CYCLES = 4,
    parameter int TIMEOUT    = 16,
    parameter int PRICE_W    = 10,
    parameter int TOTAL_W    = 14
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic [3:0]          KEY,
    input  logic [2:0]          SW,
    sale_entry_ctrl_if.master   bus,
    output logic [2*DIGITS-1:0] entry_code,
    output logic [2:0]          digit_count,
    output logic [TOTAL_W-1:0]  total,
    output logic [7:0]          item_count,
    output logic                err,
    output logic                busy,
    output logic [2:0]          fsm_state
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        REQ   = 3'd2,
        WAIT  = 3'd3,
        ERROR = 3'd4
    } state_t;

    localparam int         CW   = $clog2(DEB_CYCLES + 1);
    localparam int         WW   = $clog2(TIMEOUT + 1);
    localparam logic [2:0] FULL = 3'(DIGITS);

    state_t              state, next_state;
    logic [3:0]          key_s1, key_s2, armed, fire, key_pulse;
    logic [CW-1:0]       low_cnt [4];
    logic [1:0]          sw_s1, sw_s2;
    logic                unused_sw;
    logic                sel_p, dig_p, full, confirm, checkout;
    logic [1:0]          dig_val;
    logic [WW-1:0]       wait_cnt;
    logic [2*DIGITS-1:0] code_q;
    logic [TOTAL_W:0]    sum;
    logic [TOTAL_W-1:0]  sat_total;

    assign unused_sw = SW[1];

    // A key is armed only after it has been seen released, so a key held through reset cannot fire.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            key_s1    <= '0;
            key_s2    <= '0;
            sw_s1     <= '0;
            sw_s2     <= '0;
            armed     <= '0;
            key_pulse <= '0;
            for (int i = 0; i < 4; i++) low_cnt[i] <= '0;
        end else begin
            key_s1    <= KEY;
            key_s2    <= key_s1;
            sw_s1     <= {SW[2], SW[0]};
            sw_s2     <= sw_s1;
            key_pulse <= fire;
            for (int i = 0; i < 4; i++) begin
                if (key_s2[i]) begin
                    low_cnt[i] <= '0;
                    armed[i]   <= 1'b1;
                end else if (low_cnt[i] != CW'(DEB_CYCLES)) begin
                    low_cnt[i] <= low_cnt[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        fire = '0;
        for (int i = 0; i < 4; i++)
            fire[i] = armed[i] & ~key_s2[i] & (low_cnt[i] == CW'(DEB_CYCLES - 1));
    end

    assign sel_p     = key_pulse[0];
    assign dig_p     = ~key_pulse[0] & (|key_pulse[3:1]);
    assign dig_val   = key_pulse[3] ? 2'd1 : (key_pulse[2] ? 2'd2 : 2'd3);
    assign confirm   = sw_s2[0];
    assign checkout  = sw_s2[1];
    assign full      = (digit_count == FULL);
    assign sum       = {1'b0, total} + (TOTAL_W + 1)'(bus.lookup_price);
    assign sat_total = sum[TOTAL_W] ? '1 : sum[TOTAL_W-1:0];

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, ENTRY: begin
                if (sel_p) begin
                    if (confirm) next_state = full ? REQ : ERROR;
                    else         next_state = IDLE;
                end else if (dig_p && !full) begin
                    next_state = ENTRY;
                end
            end
            REQ:   next_state = WAIT;
            WAIT: begin
                if (bus.lookup_ack)                        next_state = bus.lookup_hit ? IDLE : ERROR;
                else if (wait_cnt == WW'(TIMEOUT - 1))     next_state = ERROR;
            end
            ERROR: if (sel_p) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.lookup_req = 1'b0;
        busy           = 1'b0;
        err            = 1'b0;
        case (state)
            REQ, WAIT: begin
                bus.lookup_req = 1'b1;
                busy           = 1'b1;
            end
            ERROR:   err = 1'b1;
            default: ;
        endcase
    end

    assign bus.lookup_code = code_q;
    assign fsm_state       = state;

    // Entry, lookup code and sale totals; the entry stays visible while in ERROR.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            entry_code  <= '0;
            digit_count <= '0;
            total       <= '0;
            item_count  <= '0;
            code_q      <= '0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE, ENTRY: begin
                    if (sel_p) begin
                        if (confirm) begin
                            if (full) code_q <= entry_code;
                        end else begin
                            entry_code  <= '0;
                            digit_count <= '0;
                            if (checkout) begin
                                total      <= '0;
                                item_count <= '0;
                            end
                        end
                    end else if (dig_p && !full) begin
                        entry_code  <= {entry_code[2*DIGITS-3:0], dig_val};
                        digit_count <= digit_count + 3'd1;
                    end
                end
                REQ: wait_cnt <= '0;
                WAIT: begin
                    wait_cnt <= wait_cnt + WW'(1);
                    if (bus.lookup_ack && bus.lookup_hit) begin
                        total       <= sat_total;
                        item_count  <= item_count + 8'd1;
                        entry_code  <= '0;
                        digit_count <= '0;
                    end
                end
                ERROR: begin
                    if (sel_p) begin
                        entry_code  <= '0;
                        digit_count <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sale_entry_ctrl.sv
// Directed bench for sale_entry_ctrl: a transaction-level model of the sale terminal
// (digit list, integer total, item counter, error flag) is compared against the DUT.
module tb_sale_entry_ctrl;
    localparam int TIMEOUT = 16;
    localparam int MAX_TOT = 16383;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key;
    logic [2:0] sw;
    logic [7:0] entry_code;
    logic [2:0] digit_count;
    logic [13:0] total;
    logic [7:0] item_count;
    logic       err, busy;
    logic [2:0] fsm_state;

    sale_entry_ctrl_if #(.DIGITS(4), .PRICE_W(10)) bus();

    sale_entry_ctrl dut (
        .CLOCK_50    (clk),
        .RESET       (rst),
        .KEY         (key),
        .SW          (sw),
        .bus         (bus.master),
        .entry_code  (entry_code),
        .digit_count (digit_count),
        .total       (total),
        .item_count  (item_count),
        .err         (err),
        .busy        (busy),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic       chk_en = 1'b0;
    logic [7:0] exp_q[$];

    // Model of the terminal, kept in plain terms.
    int m_digits[$];
    int m_total = 0;
    int m_items = 0;
    bit m_err   = 0;

    function automatic logic [7:0] model_code();
        logic [7:0] c;
        c = '0;
        foreach (m_digits[i]) c = {c[5:0], 2'(m_digits[i])};
        return c;
    endfunction

    function automatic int dig_of(input int k);
        return (k == 3) ? 1 : ((k == 2) ? 2 : 3);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("entry_code", entry_code, model_code());
            check("digit_count", digit_count, m_digits.size());
            check("total", total, m_total);
            check("item_count", item_count, m_items);
            check("err", err, m_err);
            check("busy_idle", busy, 32'd0);
            check("lookup_req_idle", bus.lookup_req, 32'd0);
        end
    end

    task automatic settle();
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 chk_en = 1'b0;
    endtask

    task automatic set_sw(input logic [2:0] v);
        @(posedge clk);
        #1 sw = v;
        repeat (3) @(posedge clk);
    endtask

    task automatic press_mask(input logic [3:0] mask, input int hold);
        @(posedge clk);
        #1 key = key & ~mask;
        repeat (hold) @(posedge clk);
        #1 key = key | mask;
        repeat (4) @(posedge clk);
    endtask

    task automatic m_select(input logic [2:0] s);
        if (m_err) begin
            m_err = 0;
            m_digits.delete();
        end else if (s[0]) begin
            if (m_digits.size() < 4) m_err = 1;
        end else begin
            if (s[2]) begin
                m_total = 0;
                m_items = 0;
            end
            m_digits.delete();
        end
    endtask

    task automatic digit(input int k);
        press_mask(4'(1 << k), 10);
        if (m_digits.size() < 4) m_digits.push_back(dig_of(k));
        settle();
    endtask

    task automatic do_select();
        press_mask(4'b0001, 10);
        m_select(sw);
        settle();
    endtask

    task automatic wait_req(output bit ok);
        int n;
        n  = 0;
        ok = 0;
        while (n < 30) begin
            @(negedge clk);
            if (bus.lookup_req) begin
                ok = 1;
                break;
            end
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL lookup_req_wait: lookup_req stayed 0 for 30 cycles, expected 1");
        end
    endtask

    // mode 0 = hit, 1 = miss, 2 = no acknowledge
    task automatic do_lookup(input int mode, input int price);
        bit ok;
        exp_q.push_back(model_code());
        @(posedge clk);
        #1 key[0] = 1'b0;
        wait_req(ok);
        if (ok) begin
            check("lookup_code", bus.lookup_code, exp_q.pop_front());
            check("busy_lookup", busy, 32'd1);
            if (mode < 2) begin
                repeat (2) @(negedge clk);
                check("req_held", bus.lookup_req, 32'd1);
                bus.lookup_ack   = 1'b1;
                bus.lookup_hit   = (mode == 0);
                bus.lookup_price = 10'(price);
                @(negedge clk);
                bus.lookup_ack   = 1'b0;
                bus.lookup_hit   = 1'b0;
                bus.lookup_price = '0;
                check("req_after_ack", bus.lookup_req, 32'd0);
            end else begin
                repeat (TIMEOUT - 2) @(negedge clk);
                check("req_before_timeout", bus.lookup_req, 32'd1);
                repeat (4) @(negedge clk);
                check("req_after_timeout", bus.lookup_req, 32'd0);
            end
        end else begin
            void'(exp_q.pop_front());
        end
        @(posedge clk);
        #1 key[0] = 1'b1;
        repeat (4) @(posedge clk);
        if (mode == 0) begin
            m_total = (m_total + price > MAX_TOT) ? MAX_TOT : m_total + price;
            m_items = (m_items + 1) % 256;
            m_digits.delete();
        end else begin
            m_err = 1;
        end
        settle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        key = 4'hF;
        sw  = 3'b000;
        rst = 1'b1;
        bus.lookup_ack   = 1'b0;
        bus.lookup_hit   = 1'b0;
        bus.lookup_price = '0;

        // Reset state
        repeat (2) @(posedge clk);
        settle();
        @(negedge clk) rst = 1'b0;
        repeat (4) @(posedge clk);
        settle();

        // KEY3,KEY2,KEY3,KEY1 -> 1,2,1,3
        digit(3); digit(2); digit(3); digit(1);
        check("lit_entry_67", entry_code, 32'h67);
        check("lit_count_4", digit_count, 32'd4);

        // Reset in the middle of a lookup
        set_sw(3'b001);
        exp_q.push_back(model_code());
        @(posedge clk);
        #1 key[0] = 1'b0;
        wait_req(ok);
        if (ok) begin
            check("rst_lookup_code", bus.lookup_code, exp_q.pop_front());
            repeat (3) @(negedge clk);
            #2 rst = 1'b1;
            #1;
            check("rst_req_drop", bus.lookup_req, 32'd0);
            check("rst_busy_drop", busy, 32'd0);
            check("rst_total", total, 32'd0);
            @(negedge clk) rst = 1'b0;
        end else begin
            void'(exp_q.pop_front());
        end
        @(posedge clk);
        #1 key[0] = 1'b1;
        repeat (4) @(posedge clk);
        m_digits.delete();
        m_total = 0; m_items = 0; m_err = 0;
        settle();

        // Hit with price 25
        digit(3); digit(2); digit(3); digit(1);
        do_lookup(0, 25);
        check("lit_total_25", total, 32'd25);
        check("lit_items_1", item_count, 32'd1);

        // Miss keeps the total and flags the error; select clears it
        digit(3); digit(2); digit(3); digit(1);
        do_lookup(1, 0);
        check("lit_err_miss", err, 32'd1);
        do_select();
        check("lit_err_cleared", err, 32'd0);

        // Confirm with only two digits
        digit(1); digit(2);
        check("lit_entry_two", entry_code, 32'h0E);
        do_select();
        check("lit_err_short", err, 32'd1);
        do_select();

        // Fifth digit is ignored, then a hit with price 100
        digit(1); digit(1); digit(2); digit(3);
        digit(2);
        check("lit_entry_f9", entry_code, 32'hF9);
        do_lookup(0, 100);
        check("lit_total_125", total, 32'd125);

        // Debounce boundary: 3 low cycles rejected, 4 accepted
        set_sw(3'b000);
        press_mask(4'b1000, 3);
        settle();
        press_mask(4'b1000, 4);
        m_digits.push_back(1);
        settle();
        check("lit_deb_4", digit_count, 32'd1);

        // KEY0 and KEY3 together: only the select acts
        press_mask(4'b1001, 10);
        m_select(sw);
        settle();
        check("lit_simul_count", digit_count, 32'd0);

        // Acknowledge outside WAIT is ignored
        @(negedge clk);
        bus.lookup_ack = 1'b1; bus.lookup_hit = 1'b1; bus.lookup_price = 10'd100;
        @(negedge clk);
        bus.lookup_ack = 1'b0; bus.lookup_hit = 1'b0; bus.lookup_price = '0;
        settle();

        // Timeout
        set_sw(3'b001);
        digit(2); digit(2); digit(2); digit(2);
        do_lookup(2, 0);
        check("lit_err_timeout", err, 32'd1);
        do_select();

        // Saturation: 125 + 16*1023 exceeds 16383
        for (int i = 0; i < 16; i++) begin
            digit(1 + (i % 3)); digit(3); digit(2); digit(1 + ((i + 1) % 3));
            do_lookup(0, 1023);
        end
        check("lit_total_sat", total, 32'd16383);
        check("lit_items_18", item_count, 32'd18);

        // Checkout clears the sale
        set_sw(3'b100);
        digit(3);
        do_select();
        check("lit_checkout_total", total, 32'd0);
        check("lit_checkout_items", item_count, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
